// File: rtl/shift_accum_seq.sv
// Capture sequencer for the shift-accumulate RAM (bit-serial codes).
// Ports: clk_in/rst_in; bit_in stream; acc_* RAM request/result; code_*, frame_out, busy_out, done_out.
package shift_accum_pkg;
   typedef enum logic {
      ACC_READ  = 1'b0,
      ACC_WRITE = 1'b1
   } accum_request_t;
endpackage

module shift_accum_seq
   import shift_accum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       start_in,
   input  logic                       bit_in,
   input  logic                       bit_valid_in,
   output logic                       bit_ready_out,
   output logic [$clog2(DEPTH)-1:0]   acc_addr_out,
   output logic                       acc_summand_out,
   output accum_request_t             acc_request_type_out,
   output logic                       acc_request_valid_out,
   input  logic [WIDTH-1:0]           acc_read_in,
   input  logic [$clog2(DEPTH)-1:0]   acc_addr_in,
   input  accum_request_t             acc_request_type_in,
   input  logic                       acc_result_valid_in,
   output logic [WIDTH-1:0]           code_out,
   output logic [$clog2(DEPTH)-1:0]   code_addr_out,
   output logic                       code_valid_out,
   output logic [$clog2(WIDTH+1)-1:0] frame_out,
   output logic                       busy_out,
   output logic                       done_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(WIDTH + 1);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [FW-1:0] LAST_FRAME = FW'(WIDTH - 1);

   // Address reuse distance within a frame must exceed the RAM's
   // 2-cycle read-modify-write, so at least three addresses are needed.
   if (DEPTH < 3) begin : g_depth_check
      $error("shift_accum_seq: DEPTH must be >= 3");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_READOUT,
      S_DRAIN
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [FW-1:0]  frame_q, frame_d;
   logic           drain_q, drain_d;

   logic           hs;

   logic           req_valid_d;
   logic [AW-1:0]  req_addr_d;
   logic           req_sum_d;
   accum_request_t req_type_d;
   logic           code_valid_d;
   logic           done_d;

   assign hs = (state_q == S_ACCUM) && bit_valid_in;

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         frame_q <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         frame_q <= frame_d;
         drain_q <= drain_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      frame_d = frame_q;
      drain_d = drain_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_ACCUM;
               addr_d  = '0;
               frame_d = '0;
            end
         end
         S_ACCUM: begin
            if (hs) begin
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  frame_d = frame_q + 1'b1;
                  if (frame_q == LAST_FRAME) begin
                     state_d = S_READOUT;
                  end
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         S_READOUT: begin
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               drain_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // Two cycles cover the reads still inside the RAM pipeline.
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: next values of the registered outputs
   always_comb begin
      req_valid_d  = 1'b0;
      req_addr_d   = acc_addr_out;
      req_sum_d    = 1'b0;
      req_type_d   = acc_request_type_out;
      done_d       = 1'b0;
      code_valid_d = acc_result_valid_in &&
                     (acc_request_type_in == ACC_READ);
      unique case (1'b1)
         hs: begin
            req_valid_d = 1'b1;
            req_addr_d  = addr_q;
            req_sum_d   = bit_in;
            req_type_d  = ACC_WRITE;
         end
         (state_q == S_READOUT): begin
            req_valid_d = 1'b1;
            req_addr_d  = addr_q;
            req_type_d  = ACC_READ;
         end
         (state_q == S_DRAIN): begin
            done_d = drain_q;
         end
         default: begin
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         acc_addr_out          <= '0;
         acc_summand_out       <= 1'b0;
         acc_request_type_out  <= ACC_READ;
         acc_request_valid_out <= 1'b0;
         code_out              <= '0;
         code_addr_out         <= '0;
         code_valid_out        <= 1'b0;
         done_out              <= 1'b0;
      end else begin
         acc_addr_out          <= req_addr_d;
         acc_summand_out       <= req_sum_d;
         acc_request_type_out  <= req_type_d;
         acc_request_valid_out <= req_valid_d;
         code_valid_out        <= code_valid_d;
         done_out              <= done_d;
         if (code_valid_d) begin
            code_out      <= acc_read_in;
            code_addr_out <= acc_addr_in;
         end
      end
   end

   assign bit_ready_out = (state_q == S_ACCUM);
   assign busy_out      = (state_q != S_IDLE);
   assign frame_out     = frame_q;

endmodule

// File: tb/tb_shift_accum_seq.sv
// Directed bench for shift_accum_seq with a 2-cycle RMW RAM model.
// WIDTH=4, DEPTH=4; codes assemble MSB-first from frame 0.
module tb_shift_accum_seq;
   import shift_accum_pkg::*;

   localparam int W = 4;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst_in = 1'b1;
   logic           start_in = 1'b0;
   logic           bit_in = 1'b0;
   logic           bit_valid_in = 1'b0;
   logic           bit_ready_out;
   logic [1:0]     acc_addr_out;
   logic           acc_summand_out;
   accum_request_t acc_request_type_out;
   logic           acc_request_valid_out;
   logic [W-1:0]   acc_read_in;
   logic [1:0]     acc_addr_in;
   accum_request_t acc_request_type_in;
   logic           acc_result_valid_in;
   logic [W-1:0]   code_out;
   logic [1:0]     code_addr_out;
   logic           code_valid_out;
   logic [2:0]     frame_out;
   logic           busy_out;
   logic           done_out;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   shift_accum_seq #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_in                (clk),
      .rst_in                (rst_in),
      .start_in              (start_in),
      .bit_in                (bit_in),
      .bit_valid_in          (bit_valid_in),
      .bit_ready_out         (bit_ready_out),
      .acc_addr_out          (acc_addr_out),
      .acc_summand_out       (acc_summand_out),
      .acc_request_type_out  (acc_request_type_out),
      .acc_request_valid_out (acc_request_valid_out),
      .acc_read_in           (acc_read_in),
      .acc_addr_in           (acc_addr_in),
      .acc_request_type_in   (acc_request_type_in),
      .acc_result_valid_in   (acc_result_valid_in),
      .code_out              (code_out),
      .code_addr_out         (code_addr_out),
      .code_valid_out        (code_valid_out),
      .frame_out             (frame_out),
      .busy_out              (busy_out),
      .done_out              (done_out)
   );

   // RAM model: request sampled at an edge, result visible the
   // following cycle, shifted value written back one edge later.
   logic [W-1:0]   mem [D];
   logic           s_valid;
   logic [1:0]     s_addr;
   accum_request_t s_type;
   logic           s_sum;
   logic [W-1:0]   s_data;
   logic           preload = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (preload) begin
         for (int i = 0; i < D; i++) mem[i] <= 4'hF;
      end else if (s_valid && s_type == ACC_WRITE) begin
         mem[s_addr] <= {s_data[W-2:0], s_sum};
      end
      if (rst_in) begin
         s_valid <= 1'b0;
      end else begin
         s_valid <= acc_request_valid_out;
      end
      s_addr <= acc_addr_out;
      s_type <= acc_request_type_out;
      s_sum  <= acc_summand_out;
      s_data <= mem[acc_addr_out];
   end

   assign acc_read_in         = s_data;
   assign acc_addr_in         = s_addr;
   assign acc_request_type_in = s_type;
   assign acc_result_valid_in = s_valid;

   // Output log
   int         ncode = 0;
   int         ndone = 0;
   int         done_cyc = 0;
   int         log_cyc [64];
   logic [1:0] log_addr [64];
   logic [3:0] log_val [64];

   always @(negedge clk) begin
      if (code_valid_out === 1'b1) begin
         if (ncode < 64) begin
            log_cyc[ncode]  = cyc;
            log_addr[ncode] = code_addr_out;
            log_val[ncode]  = code_out;
         end
         ncode = ncode + 1;
      end
      if (done_out === 1'b1) begin
         done_cyc = cyc;
         ndone    = ndone + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_addr", 32'(acc_addr_out), 0);
      chk("rst_sum", 32'(acc_summand_out), 0);
      chk("rst_type", 32'(acc_request_type_out), 32'(ACC_READ));
      chk("rst_valid", 32'(acc_request_valid_out), 0);
      chk("rst_code", 32'(code_out), 0);
      chk("rst_caddr", 32'(code_addr_out), 0);
      chk("rst_cvalid", 32'(code_valid_out), 0);
      chk("rst_frame", 32'(frame_out), 0);
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_done", 32'(done_out), 0);
      chk("rst_ready", 32'(bit_ready_out), 0);
   endtask

   // codes[a] is the expected final code of address a; frame f sends
   // bit codes[a][3-f].
   task automatic run_capture(input logic [3:0][3:0] codes,
                              input bit stall, input int abort_f,
                              input bit poke);
      int  e_cyc;
      int  c0;
      int  d0;
      int  run;
      logic v;
      logic b;
      c0  = ncode;
      d0  = ndone;
      run = 0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      chk("start_busy", 32'(busy_out), 1);
      chk("start_ready", 32'(bit_ready_out), 1);
      for (int f = 0; f < W; f++) begin
         for (int a = 0; a < D; a++) begin
            if (f == abort_f && a == 0) begin
               rst_in       = 1'b1;
               bit_valid_in = 1'b0;
               tick();
               rst_in = 1'b0;
               chk_reset_state();
               return;
            end
            b = codes[a][3-f];
            do begin
               if (stall && run < 3) v = 1'($urandom_range(0, 1));
               else v = 1'b1;
               bit_valid_in = v;
               bit_in       = v ? b : ~b;
               tick();
               chk("req_valid", 32'(acc_request_valid_out), 32'(v));
               if (v) begin
                  chk("req_addr", 32'(acc_addr_out), 32'(a));
                  chk("req_sum", 32'(acc_summand_out), 32'(b));
                  chk("req_type", 32'(acc_request_type_out),
                      32'(ACC_WRITE));
                  run = 0;
               end else begin
                  run++;
               end
            end while (!v);
         end
      end
      bit_valid_in = 1'b0;
      e_cyc = cyc;
      chk("ro_ready", 32'(bit_ready_out), 0);
      chk("ro_frame", 32'(frame_out), W);
      chk("ro_busy", 32'(busy_out), 1);
      if (poke) begin
         start_in = 1'b1;
         tick();
         start_in = 1'b0;
      end
      for (int i = 0; i < 20; i++) begin
         if (ndone != d0) break;
         tick();
      end
      chk("done_count", 32'(ndone - d0), 1);
      chk("done_time", 32'(done_cyc - e_cyc), 6);
      chk("code_count", 32'(ncode - c0), 4);
      for (int k = 0; k < D; k++) begin
         chk("code_addr", 32'(log_addr[c0+k]), 32'(k));
         chk("code_val", 32'(log_val[c0+k]), 32'(codes[k]));
         chk("code_time", 32'(log_cyc[c0+k] - e_cyc), 32'(3 + k));
      end
      chk("end_busy", 32'(busy_out), 0);
      chk("end_frame", 32'(frame_out), W);
   endtask

   initial begin
      int c_end;
      int d_end;
      tick();
      tick();
      chk_reset_state();
      rst_in = 1'b0;
      tick();
      chk("idle_busy", 32'(busy_out), 0);

      // Reset in the middle of accumulation, then a full capture
      run_capture({4'h1, 4'h6, 4'h4, 4'hB}, 1'b0, 2, 1'b0);
      tick();
      chk("abort_idle", 32'(busy_out), 0);
      run_capture({4'h1, 4'h6, 4'h4, 4'hB}, 1'b0, -1, 1'b0);

      // Stalled stream gives identical codes
      tick();
      run_capture({4'h1, 4'h6, 4'h4, 4'hB}, 1'b1, -1, 1'b0);

      // Stale contents are shifted out by a zero capture
      tick();
      preload = 1'b1;
      tick();
      preload = 1'b0;
      run_capture({4'h0, 4'h0, 4'h0, 4'h0}, 1'b0, -1, 1'b0);

      // Start during readout is ignored
      tick();
      run_capture({4'h9, 4'hC, 4'h3, 4'h5}, 1'b0, -1, 1'b1);

      // Back-to-back capture straight after done
      run_capture({4'h2, 4'hE, 4'h7, 4'hA}, 1'b1, -1, 1'b0);

      c_end = ncode;
      d_end = ndone;
      for (int i = 0; i < 10; i++) tick();
      chk("quiet_codes", 32'(ncode - c_end), 0);
      chk("quiet_done", 32'(ndone - d_end), 0);
      chk("quiet_busy", 32'(busy_out), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
